// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding, minimum ratio and ratio clamp
// for the programmable clock-divider controller.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SWITCH,
    STOP
  } state_e;

  // A ratio below DIV_MIN cannot form a clock period, so it is raised to DIV_MIN.
  function automatic int unsigned clamp_div(input int unsigned div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// clk_div_counter: period counter, boundary compare and high-phase compare
// for clk_div_ctrl. Optional macro CLK_DIV_ODD50_EN adds a falling-edge flop
// so odd ratios get an exact 50% duty cycle.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             boundary,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             hi_pos_q, hi_pos_d;
  logic             tick_q, tick_d;
  logic [DIV_W:0]   half;
  logic             hi_phase;

  assign half     = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
  assign boundary = (cnt_q == div - DIV_W'(1));
  assign hi_phase = ({1'b0, cnt_q} < half);

  // Count 0..N-1 while running; the output flop follows the count one cycle later.
  always_comb begin
    cnt_d    = '0;
    hi_pos_d = 1'b0;
    tick_d   = 1'b0;
    if (run) begin
      cnt_d    = boundary ? '0 : cnt_q + DIV_W'(1);
      hi_pos_d = hi_phase;
      tick_d   = (cnt_q == '0);
    end
  end

  // Rising-edge state: counter, high-phase flop and tick pulse.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      hi_pos_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_pos_q <= hi_pos_d;
      tick_q   <= tick_d;
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic hi_neg_q, hi_neg_d;

  assign hi_neg_d = hi_pos_q;

  // Half-cycle delayed copy of the high phase, used to trim odd ratios to 50% duty.
  always_ff @(negedge clk_in or posedge reset) begin
    if (reset) begin
      hi_neg_q <= 1'b0;
    end else begin
      hi_neg_q <= hi_neg_d;
    end
  end

  assign clk_out = div[0] ? (hi_pos_q & hi_neg_q) : hi_pos_q;
`else
  assign clk_out = hi_pos_q;
`endif

  assign tick = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time programmable integer clock divider. Starts, stops and
// changes ratio only at period boundaries. Optional macro CLK_DIV_ODD50_EN
// gives odd ratios an exact 50% duty cycle.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 6
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [DIV_W-1:0] div_cur
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_nxt_q, div_nxt_d;
  logic             pend_q, pend_d;
  logic             accept;
  logic             boundary;
  logic [DIV_W-1:0] div_in;

  assign running   = (state_q != IDLE);
  assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
  assign accept    = cfg_valid && cfg_ready;
  assign div_in    = DIV_W'(clamp_div(32'(cfg_div)));
  assign cfg_err   = accept && (32'(cfg_div) < DIV_MIN);
  assign div_cur   = div_cur_q;

  // Next-state logic: ratio updates and run/stop decisions only take hold at boundaries.
  always_comb begin
    state_d   = state_q;
    div_cur_d = div_cur_q;
    div_nxt_d = div_nxt_q;
    pend_d    = pend_q;
    case (state_q)
      IDLE: begin
        if (accept) div_cur_d = div_in;
        if (clk_en) state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          div_nxt_d = div_in;
          pend_d    = 1'b1;
        end
        // A drop seen on the last cycle of a period halts right away rather than
        // running a whole extra period.
        if (!clk_en) state_d = (boundary && !accept) ? IDLE : STOP;
        else if (accept) state_d = SWITCH;
      end
      SWITCH: begin
        if (boundary) begin
          div_cur_d = div_nxt_q;
          pend_d    = 1'b0;
          state_d   = clk_en ? RUN : STOP;
        end
      end
      STOP: begin
        if (boundary) begin
          if (pend_q) begin
            div_cur_d = div_nxt_q;
            pend_d    = 1'b0;
          end
          state_d = clk_en ? RUN : IDLE;
        end else if (clk_en) begin
          state_d = pend_q ? SWITCH : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset drops any pending ratio.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cur_q <= DIV_W'(DIV_RESET);
      div_nxt_q <= DIV_W'(DIV_RESET);
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cur_q <= div_cur_d;
      div_nxt_q <= div_nxt_d;
      pend_q    <= pend_d;
    end
  end

  clk_div_counter #(
    .DIV_W(DIV_W)
  ) u_counter (
    .clk_in  (clk_in),
    .reset   (reset),
    .run     (running),
    .div     (div_cur_q),
    .boundary(boundary),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed bench for clk_div_ctrl. Stimulus pushes the
// expected shape of every output period; a monitor measures each period
// between ticks (or until running falls) and compares against the queue.
module tb_clk_div_ctrl;

  logic       clk_in;
  logic       reset;
  logic       clk_en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic       running;
  logic [7:0] div_cur;

  typedef struct {
    int len;
    int hi;
    bit stop;
  } period_t;

  period_t exp_q[$];
  int      n_checks = 0;
  int      n_pass   = 0;
  int      ph_len   = 0;
  int      ph_hi    = 0;
  bit      in_period = 0;

  clk_div_ctrl #(
    .DIV_W    (8),
    .DIV_RESET(6)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .clk_en   (clk_en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .running  (running),
    .div_cur  (div_cur)
  );

  // Free-running source clock.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Hard stop in case the sequence ever wedges.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endfunction

  // High cycles per period as seen one step after each rising edge.
  function automatic int exp_hi(input int n);
`ifdef CLK_DIV_ODD50_EN
    return (n % 2 == 1) ? n / 2 : n / 2;
`else
    return (n + 1) / 2;
`endif
  endfunction

  function automatic void push_period(input int n, input bit stop);
    period_t p;
    p.len  = n;
    p.hi   = exp_hi(n);
    p.stop = stop;
    exp_q.push_back(p);
  endfunction

  function automatic void close_period(input bit by_stop);
    period_t e;
    if (exp_q.size() == 0) begin
      check_output("pending_expectations", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    check_output("period_len", ph_len, e.len);
    check_output("period_high", ph_hi, e.hi);
    check_output("period_end_by_stop", int'(by_stop), int'(e.stop));
  endfunction

  // Monitor: measure every output period and score it against the queue.
  always @(posedge clk_in) begin
    #1;
    if (reset) begin
      in_period = 1'b0;
    end else if (tick) begin
      if (in_period) close_period(1'b0);
      in_period = 1'b1;
      ph_len    = 1;
      ph_hi     = clk_out ? 1 : 0;
    end else if (in_period) begin
      ph_len++;
      if (clk_out) ph_hi++;
      if (!running) begin
        close_period(1'b1);
        in_period = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input logic en, input logic valid, input logic [7:0] div);
    @(negedge clk_in);
    clk_en    = en;
    cfg_valid = valid;
    cfg_div   = div;
    #1;
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk_in);
      #1;
      seen = tick;
    end
    check_output({"tick_seen_", tag}, int'(seen), 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 32 && running; i++) begin
      @(posedge clk_in);
      #1;
    end
    check_output({"stopped_", tag}, int'(running), 0);
    check_output({"clk_out_low_", tag}, int'(clk_out), 0);
  endtask

  initial begin
    reset     = 1'b1;
    clk_en    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    repeat (2) @(negedge clk_in);
    #1;
    check_output("rst_clk_out", int'(clk_out), 0);
    check_output("rst_tick", int'(tick), 0);
    check_output("rst_cfg_err", int'(cfg_err), 0);
    check_output("rst_cfg_ready", int'(cfg_ready), 1);
    check_output("rst_running", int'(running), 0);
    check_output("rst_div_cur", int'(div_cur), 6);
    @(negedge clk_in);
    reset = 1'b0;

    // Start at the reset ratio of 6.
    push_period(6, 1'b0);
    push_period(6, 1'b0);
    push_period(6, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    @(posedge clk_in);
    #1;
    check_output("start_running", int'(running), 1);
    check_output("start_clk_out_first", int'(clk_out), 0);
    check_output("start_tick_first", int'(tick), 0);
    @(posedge clk_in);
    #1;
    check_output("start_tick", int'(tick), 1);
    check_output("start_clk_out", int'(clk_out), 1);
    check_output("start_div_cur", int'(div_cur), 6);
    wait_tick("t2");
    wait_tick("t3");

    // Change 6 -> 4 while cnt = 2.
    apply_stimulus(1'b1, 1'b0, 8'd0);
    apply_stimulus(1'b1, 1'b1, 8'd4);
    check_output("ready_before_switch", int'(cfg_ready), 1);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    check_output("ready_in_switch", int'(cfg_ready), 0);
    check_output("div_cur_pending", int'(div_cur), 6);
    push_period(4, 1'b0);
    wait_tick("t4");
    check_output("div_cur_4", int'(div_cur), 4);
    check_output("ready_after_switch", int'(cfg_ready), 1);

    // Ratio 0 is clamped to 2.
    apply_stimulus(1'b1, 1'b1, 8'd0);
    check_output("cfg_err_pulse", int'(cfg_err), 1);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    check_output("cfg_err_clear", int'(cfg_err), 0);
    for (int i = 0; i < 5; i++) push_period(2, 1'b0);
    wait_tick("t5");
    check_output("div_cur_clamped", int'(div_cur), 2);
    wait_tick("t6");
    wait_tick("t7");
    wait_tick("t8");
    wait_tick("t9");

    // Accept 5 exactly on a boundary cycle: one more period at 2 first.
    apply_stimulus(1'b1, 1'b1, 8'd5);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    check_output("ready_switch_at_boundary", int'(cfg_ready), 0);
    check_output("div_cur_still_2", int'(div_cur), 2);
    push_period(2, 1'b0);
    push_period(5, 1'b1);
    wait_tick("t10");
    wait_tick("t11");
    check_output("div_cur_5", int'(div_cur), 5);

    // Drop clk_en at cnt = 1 with N = 5: period completes, then halt.
    apply_stimulus(1'b0, 1'b0, 8'd0);
    wait_idle("n5");

    // Drop and raise clk_en before the boundary: no gap.
    push_period(5, 1'b0);
    push_period(5, 1'b0);
    push_period(5, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    wait_tick("u1");
    wait_tick("u2");
    apply_stimulus(1'b0, 1'b0, 8'd0);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    wait_tick("u3");

    // Go to 7, then queue 3 and reset mid-switch at cnt = 3.
    apply_stimulus(1'b1, 1'b1, 8'd7);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    wait_tick("u4");
    check_output("div_cur_7", int'(div_cur), 7);
    apply_stimulus(1'b1, 1'b1, 8'd3);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    check_output("ready_switch_7_3", int'(cfg_ready), 0);
    @(negedge clk_in);
    reset  = 1'b1;
    clk_en = 1'b0;
    #1;
    check_output("midrst_clk_out", int'(clk_out), 0);
    check_output("midrst_div_cur", int'(div_cur), 6);
    check_output("midrst_running", int'(running), 0);
    check_output("midrst_cfg_ready", int'(cfg_ready), 1);
    check_output("midrst_tick", int'(tick), 0);
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    #1;
    check_output("post_rst_div_cur", int'(div_cur), 6);

    // Restart: the dropped ratio 3 must not appear.
    push_period(6, 1'b0);
    push_period(6, 1'b1);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    wait_tick("v1");
    wait_tick("v2");
    check_output("div_cur_after_restart", int'(div_cur), 6);
    apply_stimulus(1'b0, 1'b0, 8'd0);
    wait_idle("n6");
    repeat (3) @(negedge clk_in);
    check_output("leftover_expectations", exp_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
